// File: rtl/gmii_rx_frame_check.sv
// gmii_rx_frame_check: GMII receive pass-through with per-frame SFD/CRC-32/length checking.
// Optional good/bad frame counters are enabled by defining GMII_RX_STATS_EN.
module gmii_rx_frame_check #(
    parameter int PRE_MAX   = 15,
    parameter int FRAME_MIN = 64,
    parameter int FRAME_MAX = 1600
) (
    input  logic        gmii_rx_clk,
    input  logic        resetn,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  gmii_data_out,
    output logic        gmii_en_out,
    output logic        frame_done,
    output logic        crc_err,
    output logic        frame_err,
    output logic [15:0] frame_len,
    output logic [31:0] good_cnt,
    output logic [31:0] bad_cnt
);
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic        en_q, en_d;
    logic        armed_q, armed_d;
    logic [7:0]  pre_q, pre_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] len_q, len_d;
    logic        er_q, er_d;
    logic        done_q, done_d;
    logic        crc_err_q, crc_err_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] flen_q, flen_d;
    logic        eof, nosfd;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r >> 1) ^ (32'hEDB88320 & {32{r[0] ^ d[i]}});
        return r;
    endfunction

    assign eof   = (state_q != IDLE) && !gmii_rx_dv;
    assign nosfd = state_q != DATA;

    always_comb begin
        data_d      = gmii_rxd;
        en_d        = gmii_rx_dv;
        state_d     = state_q;
        pre_d       = pre_q;
        crc_d       = crc_q;
        len_d       = len_q;
        er_d        = er_q | (gmii_rx_dv & gmii_rx_er);
        // After reset a frame only starts once rx_dv has been seen low.
        armed_d     = armed_q | ~gmii_rx_dv;
        done_d      = eof;
        crc_err_d   = eof ? (nosfd || crc_q != RESIDUE) : crc_err_q;
        frame_err_d = eof ? (nosfd || er_q || len_q < 16'(FRAME_MIN) || len_q >= 16'(FRAME_MAX)) : frame_err_q;
        flen_d      = eof ? len_q : flen_q;
        if (!gmii_rx_dv) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (armed_q) begin
                    state_d = PRE;
                    pre_d   = 8'd1;
                    len_d   = '0;
                    er_d    = gmii_rx_er;
                end
                PRE: if (gmii_rxd == 8'hD5) begin
                    state_d = DATA;
                    crc_d   = '1;
                    len_d   = '0;
                end else if (gmii_rxd == 8'h55 && pre_q < 8'(PRE_MAX)) begin
                    pre_d = pre_q + 8'd1;
                end else begin
                    state_d = DROP;
                end
                DATA: begin
                    crc_d = crc_byte(crc_q, gmii_rxd);
                    len_d = (len_q == 16'(FRAME_MAX)) ? len_q : len_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge gmii_rx_clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            data_q      <= '0;
            en_q        <= 1'b0;
            armed_q     <= 1'b0;
            pre_q       <= '0;
            crc_q       <= '1;
            len_q       <= '0;
            er_q        <= 1'b0;
            done_q      <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            flen_q      <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            en_q        <= en_d;
            armed_q     <= armed_d;
            pre_q       <= pre_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            er_q        <= er_d;
            done_q      <= done_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            flen_q      <= flen_d;
        end
    end

    assign gmii_data_out = data_q;
    assign gmii_en_out   = en_q;
    assign frame_done    = done_q;
    assign crc_err       = crc_err_q;
    assign frame_err     = frame_err_q;
    assign frame_len     = flen_q;

`ifdef GMII_RX_STATS_EN
    logic [31:0] good_q, good_d, bad_q, bad_d;
    logic        frame_ok;

    assign frame_ok = !crc_err_d && !frame_err_d;

    always_comb begin
        good_d = (eof && frame_ok) ? good_q + {31'd0, ~&good_q} : good_q;
        bad_d  = (eof && !frame_ok) ? bad_q + {31'd0, ~&bad_q} : bad_q;
    end

    always_ff @(posedge gmii_rx_clk or negedge resetn) begin
        if (!resetn) begin
            good_q <= '0;
            bad_q  <= '0;
        end else begin
            good_q <= good_d;
            bad_q  <= bad_d;
        end
    end

    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;
`else
    assign good_cnt = '0;
    assign bad_cnt  = '0;
`endif
endmodule

// File: tb/tb_gmii_rx_frame_check.sv
// tb_gmii_rx_frame_check: randomized self-checking bench against a frame-level reference model.
module tb_gmii_rx_frame_check;
    localparam int PRE_MAX   = 15;
    localparam int FRAME_MIN = 64;
    localparam int FRAME_MAX = 1600;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        bit ce;
        bit fe;
        int len;
    } st_t;

    logic        gmii_rx_clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  gmii_rxd = '0;
    logic        gmii_rx_dv = 1'b0;
    logic        gmii_rx_er = 1'b0;
    logic [7:0]  gmii_data_out;
    logic        gmii_en_out;
    logic        frame_done;
    logic        crc_err;
    logic        frame_err;
    logic [15:0] frame_len;
    logic [31:0] good_cnt;
    logic [31:0] bad_cnt;

    int checks = 0;
    int errors = 0;
    st_t obs[$];
    st_t expq[$];
    logic [7:0] prev_d = '0;
    logic prev_dv = 1'b0;
    logic prev_valid = 1'b0;
    int unsigned exp_good = 0;
    int unsigned exp_bad = 0;

    always #5 gmii_rx_clk = ~gmii_rx_clk;

    gmii_rx_frame_check dut (
        .gmii_rx_clk  (gmii_rx_clk),
        .resetn       (resetn),
        .gmii_rxd     (gmii_rxd),
        .gmii_rx_dv   (gmii_rx_dv),
        .gmii_rx_er   (gmii_rx_er),
        .gmii_data_out(gmii_data_out),
        .gmii_en_out  (gmii_en_out),
        .frame_done   (frame_done),
        .crc_err      (crc_err),
        .frame_err    (frame_err),
        .frame_len    (frame_len),
        .good_cnt     (good_cnt),
        .bad_cnt      (bad_cnt)
    );

    // Standard Ethernet CRC-32 (with final inversion) over q[from..to-1].
    function automatic logic [31:0] crc32(bq_t q, int from, int to);
        logic [31:0] c;
        c = '1;
        for (int i = from; i < to; i++) begin
            c ^= {24'd0, q[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        end
        return ~c;
    endfunction

    function automatic bq_t make_frame(int npre, int npay);
        bq_t q;
        logic [31:0] c;
        q = {};
        repeat (npre) q.push_back(8'h55);
        q.push_back(8'hD5);
        repeat (npay) q.push_back(8'($urandom));
        c = crc32(q, npre + 1, q.size());
        for (int i = 0; i < 4; i++) q.push_back(c[8*i +: 8]);
        return q;
    endfunction

    // Frame-level expectation: find SFD, count bytes after it, compare FCS.
    function automatic st_t model(bq_t b, bit er);
        st_t s;
        int n, sfd, m;
        logic [31:0] fcs;
        n = b.size();
        sfd = -1;
        for (int k = 1; k < n; k++) begin
            if (b[k] == 8'hD5) begin
                sfd = k;
                break;
            end
            if (b[k] != 8'h55 || k >= PRE_MAX) break;
        end
        if (sfd < 0) begin
            s.ce = 1'b1;
            s.fe = 1'b1;
            s.len = 0;
            return s;
        end
        m = n - sfd - 1;
        s.len = (m > FRAME_MAX) ? FRAME_MAX : m;
        fcs = (m >= 4) ? {b[n-1], b[n-2], b[n-3], b[n-4]} : 32'd0;
        s.ce = !(m >= 4 && crc32(b, sfd + 1, n - 4) == fcs);
        s.fe = er || s.len < FRAME_MIN || s.len >= FRAME_MAX;
        return s;
    endfunction

    task automatic drive_cycle(input logic dv, input logic [7:0] d, input logic er);
        @(posedge gmii_rx_clk);
        #1;
        if (!resetn) begin
            checks++;
            if ({gmii_data_out, gmii_en_out, frame_done, crc_err, frame_err, frame_len, good_cnt, bad_cnt} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: data=%h en=%b done=%b len=%0d good=%0d bad=%0d, required all 0",
                         gmii_data_out, gmii_en_out, frame_done, frame_len, good_cnt, bad_cnt);
            end
        end else if (prev_valid) begin
            checks++;
            if (gmii_data_out !== prev_d || gmii_en_out !== prev_dv) begin
                errors++;
                $display("FAIL pipe_delay: data=%h en=%b, required data=%h en=%b", gmii_data_out, gmii_en_out, prev_d, prev_dv);
            end
        end
        if (frame_done === 1'b1) begin
            obs.push_back('{crc_err, frame_err, int'(frame_len)});
            checks++;
            if (gmii_en_out !== 1'b0) begin
                errors++;
                $display("FAIL done_align: en_out=%b at frame_done, required 0", gmii_en_out);
            end
        end
        gmii_rx_dv = dv;
        gmii_rxd = d;
        gmii_rx_er = er;
        prev_d = d;
        prev_dv = dv;
        prev_valid = resetn;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b0, 8'($urandom), 1'($urandom));
    endtask

    task automatic send_frame(input bq_t b, input int er_pos, input int gap);
        st_t s;
        for (int i = 0; i < b.size(); i++) drive_cycle(1'b1, b[i], 1'(i == er_pos));
        idle(gap);
        s = model(b, er_pos >= 0);
        expq.push_back(s);
        if (s.ce || s.fe) exp_bad++;
        else exp_good++;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) drive_cycle(1'b0, 8'h00, 1'b0);
        resetn = 1'b1;
        idle(2);
    endtask

    task automatic test_good;
        st_t r;
        obs.delete();
        send_frame(make_frame(7, 60), -1, 1);
        idle(2);
        checks++;
        if (obs.size() != 1) begin
            errors++;
            $display("FAIL good_count: %0d pulses, required 1", obs.size());
        end else begin
            r = obs.pop_front();
            checks++;
            if (r.ce !== 1'b0 || r.fe !== 1'b0 || r.len != 64) begin
                errors++;
                $display("FAIL good_status: ce=%0d fe=%0d len=%0d, required 0 0 64", r.ce, r.fe, r.len);
            end
        end
    endtask

    task automatic test_crc_bad;
        st_t r;
        bq_t b;
        obs.delete();
        b = make_frame(7, 60);
        b[8 + 10] ^= 8'h01;
        send_frame(b, -1, 1);
        idle(2);
        r = obs.size() > 0 ? obs.pop_front() : '{1'b0, 1'b1, -1};
        checks++;
        if (r.ce !== 1'b1 || r.fe !== 1'b0 || r.len != 64) begin
            errors++;
            $display("FAIL crc_bad: ce=%0d fe=%0d len=%0d, required 1 0 64", r.ce, r.fe, r.len);
        end
    endtask

    task automatic test_rx_er;
        st_t r;
        obs.delete();
        send_frame(make_frame(7, 60), 8 + 30, 1);
        idle(2);
        r = obs.size() > 0 ? obs.pop_front() : '{1'b1, 1'b0, -1};
        checks++;
        if (r.ce !== 1'b0 || r.fe !== 1'b1 || r.len != 64) begin
            errors++;
            $display("FAIL rx_er: ce=%0d fe=%0d len=%0d, required 0 1 64", r.ce, r.fe, r.len);
        end
    endtask

    task automatic test_no_sfd;
        st_t r;
        bq_t b;
        obs.delete();
        b = {};
        repeat (20) b.push_back(8'h55);
        send_frame(b, -1, 1);
        idle(2);
        r = obs.size() > 0 ? obs.pop_front() : '{1'b0, 1'b0, -1};
        checks++;
        if (r.ce !== 1'b1 || r.fe !== 1'b1 || r.len != 0) begin
            errors++;
            $display("FAIL no_sfd: ce=%0d fe=%0d len=%0d, required 1 1 0", r.ce, r.fe, r.len);
        end
    endtask

    task automatic test_back_to_back;
        st_t r;
        obs.delete();
        send_frame(make_frame(7, 60), -1, 1);
        send_frame(make_frame(7, 1514), -1, 1);
        idle(2);
        checks++;
        if (obs.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: %0d pulses, required 2", obs.size());
        end else begin
            r = obs.pop_front();
            checks++;
            if (r.ce || r.fe || r.len != 64) begin
                errors++;
                $display("FAIL b2b_first: ce=%0d fe=%0d len=%0d, required 0 0 64", r.ce, r.fe, r.len);
            end
            r = obs.pop_front();
            checks++;
            if (r.ce || r.fe || r.len != 1518) begin
                errors++;
                $display("FAIL b2b_second: ce=%0d fe=%0d len=%0d, required 0 0 1518", r.ce, r.fe, r.len);
            end
        end
    endtask

    task automatic test_boundaries;
        int npre[6] = '{15, 16, 7, 7, 7, 7};
        int npay[6] = '{60, 60, 59, 1595, 1596, 1601};
        bit ece[6]  = '{0, 1, 0, 0, 0, 0};
        bit efe[6]  = '{0, 1, 1, 0, 1, 1};
        int elen[6] = '{64, 0, 63, 1599, 1600, 1600};
        st_t r;
        for (int i = 0; i < 6; i++) begin
            obs.delete();
            send_frame(make_frame(npre[i], npay[i]), -1, 1);
            idle(2);
            r = obs.size() > 0 ? obs.pop_front() : '{!ece[i], !efe[i], -1};
            checks++;
            if (r.ce !== ece[i] || r.fe !== efe[i] || r.len != elen[i]) begin
                errors++;
                $display("FAIL boundary_%0d: ce=%0d fe=%0d len=%0d, required %0d %0d %0d",
                         i, r.ce, r.fe, r.len, ece[i], efe[i], elen[i]);
            end
        end
    endtask

    task automatic test_random;
        bq_t b;
        st_t r, e;
        int np;
        obs.delete();
        expq.delete();
        for (int f = 0; f < 16; f++) begin
            np = $urandom_range(70, 0);
            b = make_frame($urandom_range(17, 1), np);
            if ($urandom_range(2, 0) == 0) b[b.size() - 1 - $urandom_range(np + 3, 0)] ^= 8'h01 << $urandom_range(7, 0);
            send_frame(b, ($urandom_range(3, 0) == 0) ? $urandom_range(b.size() - 1, 0) : -1, $urandom_range(3, 1));
        end
        idle(2);
        checks++;
        if (obs.size() != expq.size()) begin
            errors++;
            $display("FAIL random_count: %0d pulses, required %0d", obs.size(), expq.size());
        end
        while (obs.size() > 0 && expq.size() > 0) begin
            r = obs.pop_front();
            e = expq.pop_front();
            checks++;
            if (r.ce !== e.ce || r.fe !== e.fe || r.len != e.len) begin
                errors++;
                $display("FAIL random_status: ce=%0d fe=%0d len=%0d, required %0d %0d %0d", r.ce, r.fe, r.len, e.ce, e.fe, e.len);
            end
        end
    endtask

    task automatic test_counters;
        int unsigned eg, eb;
`ifdef GMII_RX_STATS_EN
        eg = exp_good;
        eb = exp_bad;
`else
        eg = 0;
        eb = 0;
`endif
        checks++;
        if (good_cnt !== eg || bad_cnt !== eb) begin
            errors++;
            $display("FAIL counters: good=%0d bad=%0d, required %0d %0d", good_cnt, bad_cnt, eg, eb);
        end
    endtask

    task automatic test_reset_mid;
        bq_t b;
        st_t r;
        obs.delete();
        b = make_frame(7, 100);
        for (int i = 0; i < 40; i++) drive_cycle(1'b1, b[i], 1'b0);
        resetn = 1'b0;
        #1;
        checks++;
        if ({gmii_data_out, gmii_en_out, frame_done, crc_err, frame_err, frame_len, good_cnt, bad_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_async: en=%b len=%0d crc_err=%b frame_err=%b good=%0d bad=%0d, required all 0",
                     gmii_en_out, frame_len, crc_err, frame_err, good_cnt, bad_cnt);
        end
        for (int i = 40; i < 50; i++) drive_cycle(1'b1, b[i], 1'b0);
        resetn = 1'b1;
        exp_good = 0;
        exp_bad = 0;
        for (int i = 50; i < b.size(); i++) drive_cycle(1'b1, b[i], 1'b0);
        idle(1);
        send_frame(make_frame(7, 60), -1, 1);
        idle(2);
        checks++;
        if (obs.size() != 1) begin
            errors++;
            $display("FAIL reset_mid_count: %0d pulses, required 1", obs.size());
        end else begin
            r = obs.pop_front();
            checks++;
            if (r.ce || r.fe || r.len != 64) begin
                errors++;
                $display("FAIL reset_mid_status: ce=%0d fe=%0d len=%0d, required 0 0 64", r.ce, r.fe, r.len);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_counters();
        test_crc_bad();
        test_counters();
        test_rx_er();
        test_no_sfd();
        test_back_to_back();
        test_counters();
        test_boundaries();
        test_random();
        test_counters();
        test_reset_mid();
        test_counters();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
